// File: rtl/mux21_arb.sv
// mux21_arb: two-requester burst arbiter steering a 2:1 mux; `define MUX21_ARB_FIXED_PRIO_EN makes A always win
module mux21_arb #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             sel,
    output logic             busy
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;
    state_t state, state_nx;
    logic last, last_nx, sel_nx, own_b, own_v, xfer, full, rel, go, arb_last, pick_b;
    logic [CW-1:0] cnt, cnt_nx;
    assign own_b   = state == GNT_B;
    assign busy    = state != IDLE;
    assign own_v   = own_b ? b_valid : a_valid;
    assign y_valid = busy & own_v;
    assign a_ready = (state == GNT_A) & y_ready;
    assign b_ready = own_b & y_ready;
    assign y_data  = sel ? b_data : a_data;
    assign xfer    = y_valid & y_ready;
    assign full    = xfer & (cnt == CNT_LAST);
    assign rel     = busy & (full | ~own_v);
    assign go      = ~busy | rel;
    // On release the owner counts as most recent, so the same pick logic serves IDLE and hand-over
    assign arb_last = busy ? own_b : last;
`ifdef MUX21_ARB_FIXED_PRIO_EN
    assign pick_b = ~a_valid;
`else
    assign pick_b = b_valid & (~a_valid | ~arb_last);
`endif
    always_comb begin
        state_nx = !go ? state : !(a_valid | b_valid) ? IDLE : pick_b ? GNT_B : GNT_A;
        sel_nx   = state_nx == IDLE ? sel : state_nx == GNT_B;
        last_nx  = rel ? own_b : last;
        cnt_nx   = go ? '0 : xfer ? cnt + 1'b1 : cnt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_mux21_arb.sv
// tb_mux21_arb: directed per-cycle vectors plus hand-written reset and priority sequences
module tb_mux21_arb;
`ifdef MUX21_ARB_FIXED_PRIO_EN
    localparam int MB = 2;
`else
    localparam int MB = 4;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic a_valid = 1'b0, b_valid = 1'b0, y_ready = 1'b0;
    logic [7:0] a_data = '0, b_data = '0;
    logic a_ready, b_ready, y_valid, sel, busy;
    logic [7:0] y_data;
    int checks = 0, failures = 0;
    typedef struct {
        logic av; logic [7:0] ad; logic bv; logic [7:0] bd; logic yr;
        logic yv; logic [7:0] yd; logic ar, br, s, bz;
    } vec_t;
    vec_t tbl[$];
    mux21_arb #(.WIDTH(8), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
        .sel(sel), .busy(busy)
    );
    always #5 clk = ~clk;
    function automatic vec_t mk(logic av, logic [7:0] ad, logic bv, logic [7:0] bd, logic yr,
                                logic yv, logic [7:0] yd, logic ar, logic br, logic s, logic bz);
        vec_t v;
        v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.yr = yr;
        v.yv = yv; v.yd = yd; v.ar = ar; v.br = br; v.s = s; v.bz = bz;
        return v;
    endfunction
    task automatic drive(logic av, logic [7:0] ad, logic bv, logic [7:0] bd, logic yr);
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
    endtask
    task automatic chk(string name, logic [12:0] exp);
        logic [12:0] got;
        got = {y_valid, y_data, a_ready, b_ready, sel, busy};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got yv=%b yd=%h ar=%b br=%b sel=%b busy=%b exp yv=%b yd=%h ar=%b br=%b sel=%b busy=%b",
                     name, got[12], got[11:4], got[3], got[2], got[1], got[0],
                     exp[12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        #1 chk("reset_state", {1'b0, 8'h00, 4'b0000});
        repeat (2) @(negedge clk);
        rst = 1'b0;
`ifdef MUX21_ARB_FIXED_PRIO_EN
        @(posedge clk); #1 drive(1, 8'hA0, 1, 8'hB0, 1);
        @(negedge clk); chk("fp_idle", {1'b0, 8'hA0, 4'b0000});
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1 drive(1, 8'(i), 1, 8'hB0, 1);
            @(negedge clk); chk($sformatf("fp_a%0d", i), {1'b1, 8'(i), 4'b1001});
        end
        @(posedge clk); #1 drive(0, 8'h00, 1, 8'hB0, 1);
        @(negedge clk); chk("fp_a_drop", {1'b0, 8'h00, 4'b1001});
        @(posedge clk); #1;
        @(negedge clk); chk("fp_b_served", {1'b1, 8'hB0, 4'b0111});
`else
        // Contention from reset: A wins first, 4-beat bursts alternate with no gap
        tbl.push_back(mk(1, 8'hA0, 1, 8'hB0, 1, 0, 8'hA0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 8'hA0 + 8'(i), 1, 8'hB0, 1, 1, 8'hA0 + 8'(i), 1, 0, 0, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 8'hA4, 1, 8'hB0 + 8'(i), 1, 1, 8'hB0 + 8'(i), 0, 1, 1, 1));
        tbl.push_back(mk(1, 8'hA4, 1, 8'hB4, 1, 1, 8'hA4, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0));
        // A alone, 6 beats: re-granted after 4 without IDLE
        tbl.push_back(mk(1, 8'h10, 0, 8'h00, 1, 0, 8'h10, 0, 0, 0, 0));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 8'h10 + 8'(i), 0, 8'h00, 1, 1, 8'h10 + 8'(i), 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0));
        // Stall 10 cycles in GNT_A with B waiting, then A drops after 2 beats
        tbl.push_back(mk(1, 8'hC0, 0, 8'h00, 0, 0, 8'hC0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 8'hC0, 1, 8'hD0, 0, 1, 8'hC0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 8'hC0, 1, 8'hD0, 1, 1, 8'hC0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 8'hC1, 1, 8'hD0, 1, 1, 8'hC1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 8'hD0, 1, 0, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 8'hD0, 1, 1, 8'hD0, 0, 1, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 1, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0));
        foreach (tbl[i]) begin
            @(posedge clk); #1 drive(tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].yr);
            @(negedge clk);
            chk($sformatf("vec%0d", i), {tbl[i].yv, tbl[i].yd, tbl[i].ar, tbl[i].br, tbl[i].s, tbl[i].bz});
        end
        // Async reset mid-burst in GNT_B with two beats done
        @(posedge clk); #1 drive(0, 8'h00, 1, 8'hE0, 1);
        @(negedge clk); chk("t1_idle", {1'b0, 8'hE0, 4'b0010});
        @(posedge clk); #1;
        @(negedge clk); chk("t1_b0", {1'b1, 8'hE0, 4'b0111});
        @(posedge clk); #1 drive(0, 8'h00, 1, 8'hE1, 1);
        @(negedge clk); chk("t1_b1", {1'b1, 8'hE1, 4'b0111});
        @(posedge clk); #1 drive(0, 8'h00, 1, 8'hE2, 1);
        #2 rst = 1'b1;
        #1 chk("t1_rst_async", {1'b0, 8'h00, 4'b0000});
        @(negedge clk); rst = 1'b0; drive(0, 8'h00, 0, 8'h00, 1);
        @(posedge clk); #1 drive(1, 8'hA5, 1, 8'hB5, 1);
        @(negedge clk); chk("t1_post_idle", {1'b0, 8'hA5, 4'b0000});
        @(posedge clk); #1;
        @(negedge clk); chk("t1_a_first", {1'b1, 8'hA5, 4'b1001});
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
